// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier pipeline and its forwarding consumers.
package mult_pkg;

  localparam int unsigned MULT_XLEN       = 32;
  localparam int unsigned NUM_MULT_STAGES = 5;
  localparam int unsigned REG_ADDR_W      = 5;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'd0,
    MULT_MULH   = 2'd1,
    MULT_MULHSU = 2'd2,
    MULT_MULHU  = 2'd3
  } mult_op_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [MULT_XLEN-1:0]  data;
  } mult_stage_t;

  // Full product with RISC-V operand signedness, then low/high half select.
  function automatic logic [MULT_XLEN-1:0] mult_result(
    input mult_op_t             op,
    input logic [MULT_XLEN-1:0] a,
    input logic [MULT_XLEN-1:0] b
  );
    logic                           a_signed;
    logic                           b_signed;
    logic signed [MULT_XLEN:0]      a_ext;
    logic signed [MULT_XLEN:0]      b_ext;
    logic signed [2*MULT_XLEN-1:0]  prod;
    a_signed = (op == MULT_MULH) || (op == MULT_MULHSU);
    b_signed = (op == MULT_MULH);
    // One extra bit lets a single signed multiplier cover all three signedness modes.
    a_ext = {a_signed & a[MULT_XLEN-1], a};
    b_ext = {b_signed & b[MULT_XLEN-1], b};
    prod  = (2*MULT_XLEN)'(a_ext) * (2*MULT_XLEN)'(b_ext);
    if (op == MULT_MUL) begin
      return prod[MULT_XLEN-1:0];
    end
    return prod[2*MULT_XLEN-1:MULT_XLEN];
  endfunction

endpackage

// File: rtl/mult_stage_reg.sv
// One pipeline stage register: flush clears valid, hold freezes, otherwise loads.
module mult_stage_reg
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  mult_stage_t d,
  output mult_stage_t q
);

  // Flush wins over hold so a stalled pipe can still be emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mult_fwd_pipe.sv
// Multi-cycle multiplier pipeline producing per-stage forwarding and a
// register-file writeback request. Optional MULT_SCOREBOARD_EN adds a
// pending-write register mask derived from the stage registers.
module mult_fwd_pipe
  import mult_pkg::*;
#(
  parameter int unsigned NUM_STAGES = NUM_MULT_STAGES,
  parameter int unsigned XLEN       = MULT_XLEN
)(
  input  logic                       clk_i,
  input  logic                       rsn_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [1:0]                 in_op_i,
  input  logic [XLEN-1:0]            in_a_i,
  input  logic [XLEN-1:0]            in_b_i,
  input  logic [4:0]                 in_addr_i,
  input  logic                       flush_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            wb_data_o,
  output logic [4:0]                 wb_addr_o,
  output logic [NUM_STAGES-1:0]      fwd_wr_en_o,
  output logic [NUM_STAGES*5-1:0]    fwd_addr_o,
  output logic [NUM_STAGES*XLEN-1:0] fwd_data_o,
  output logic [31:0]                busy_mask_o
);

  mult_stage_t stage_d [NUM_STAGES];
  mult_stage_t stage_q [NUM_STAGES];
  mult_stage_t last;
  logic        last_wr;
  logic        hold;

  assign last = stage_q[NUM_STAGES-1];

  // An x0 result never requests writeback, so it can never stall the pipe.
  always_comb begin
    last_wr = last.valid && (last.addr != '0);
    hold    = last_wr && !wb_ready_i;
  end

  assign in_ready_o = !hold;
  assign wb_valid_o = last_wr;
  assign wb_data_o  = XLEN'(last.data);
  assign wb_addr_o  = last.addr;

  // Stage 1 computes the selected result; later stages shift it unchanged.
  always_comb begin
    stage_d[0].valid = in_valid_i && !hold && !flush_i;
    stage_d[0].addr  = in_addr_i;
    stage_d[0].data  = mult_result(mult_op_t'(in_op_i), MULT_XLEN'(in_a_i), MULT_XLEN'(in_b_i));
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mult_stage_reg u_stage (
      .clk   (clk_i),
      .rst_n (rsn_i),
      .hold  (hold),
      .flush (flush_i),
      .d     (stage_d[g]),
      .q     (stage_q[g])
    );
  end

  // Flatten stage contents onto the forwarding bus; every live nonzero dest asserts its bit.
  always_comb begin
    fwd_wr_en_o = '0;
    fwd_addr_o  = '0;
    fwd_data_o  = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      fwd_wr_en_o[k]          = stage_q[k].valid && (stage_q[k].addr != '0);
      fwd_addr_o[5*k +: 5]    = stage_q[k].addr;
      fwd_data_o[XLEN*k +: XLEN] = XLEN'(stage_q[k].data);
    end
  end

`ifdef MULT_SCOREBOARD_EN
  // Registers with a write still pending anywhere in the pipe.
  always_comb begin
    busy_mask_o = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (stage_q[k].valid && (stage_q[k].addr != '0)) begin
        busy_mask_o[stage_q[k].addr] = 1'b1;
      end
    end
  end
`else
  assign busy_mask_o = '0;
`endif

endmodule

// File: tb/tb_mult_fwd_pipe.sv
// Directed bench for mult_fwd_pipe: latency, op select, hold, flush, x0, same-dest and reset.
module tb_mult_fwd_pipe;

  localparam int unsigned NS = 5;
  localparam int unsigned XL = 32;

  logic              clk_i = 1'b0;
  logic              rsn_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        in_op_i;
  logic [XL-1:0]     in_a_i;
  logic [XL-1:0]     in_b_i;
  logic [4:0]        in_addr_i;
  logic              flush_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [XL-1:0]     wb_data_o;
  logic [4:0]        wb_addr_o;
  logic [NS-1:0]     fwd_wr_en_o;
  logic [NS*5-1:0]   fwd_addr_o;
  logic [NS*XL-1:0]  fwd_data_o;
  logic [31:0]       busy_mask_o;

  int checks = 0;
  int errors = 0;

  mult_fwd_pipe #(.NUM_STAGES(NS), .XLEN(XL)) dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_op_i     (in_op_i),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .in_addr_i   (in_addr_i),
    .flush_i     (flush_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_data_o   (wb_data_o),
    .wb_addr_o   (wb_addr_o),
    .fwd_wr_en_o (fwd_wr_en_o),
    .fwd_addr_o  (fwd_addr_o),
    .fwd_data_o  (fwd_data_o),
    .busy_mask_o (busy_mask_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [XL-1:0] lane(input int unsigned k);
    return fwd_data_o[XL*k +: XL];
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [XL-1:0] a,
                       input logic [XL-1:0] b, input logic [4:0] addr);
    in_valid_i = v;
    in_op_i    = op;
    in_a_i     = a;
    in_b_i     = b;
    in_addr_i  = addr;
  endtask

  // Issue one op on an idle pipe and return its writeback data after NS clocks.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [XL-1:0] a,
                        input logic [XL-1:0] b, output logic [XL-1:0] data);
    drive(1'b1, op, a, b, 5'd1);
    step();
    in_valid_i = 1'b0;
    repeat (NS-1) step();
    check({tag, "_wbv"}, 64'(wb_valid_o), 64'd1);
    data = wb_data_o;
    step();
  endtask

  logic [XL-1:0]    res;
  logic [XL-1:0]    got_q[$];
  logic [NS*XL-1:0] snap_data;
  logic [NS-1:0]    snap_en;
  logic             seen;

  initial begin
    rsn_i      = 1'b0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b1;
    drive(1'b0, 2'd0, '0, '0, '0);
    repeat (2) step();

    // Reset state.
    check("rst_wbv",   64'(wb_valid_o),  64'd0);
    check("rst_fwden", 64'(fwd_wr_en_o), 64'd0);
    check("rst_fwdad", 64'(fwd_addr_o),  64'd0);
    check("rst_fwdd",  64'(|fwd_data_o), 64'd0);
    check("rst_busy",  64'(busy_mask_o), 64'd0);
    rsn_i = 1'b1;
    #1;
    check("rst_rdy",   64'(in_ready_o),  64'd1);
    step();

    // MUL 7 x 6 -> x5, walk through the stages.
    drive(1'b1, 2'd0, 32'd7, 32'd6, 5'd5);
    check("t1_rdy", 64'(in_ready_o), 64'd1);
    step();
    in_valid_i = 1'b0;
    check("t1_st1_data", 64'(lane(0)), 64'd42);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t1_fwden_%0d", k), 64'(fwd_wr_en_o), 64'(5'd1 << k));
      check($sformatf("t1_wbv_%0d", k),   64'(wb_valid_o),  64'(k == 4));
      if (k < 4) step();
    end
    check("t1_wbdata", 64'(wb_data_o), 64'd42);
    check("t1_wbaddr", 64'(wb_addr_o), 64'd5);
    check("t1_fwdad4", 64'(fwd_addr_o[20 +: 5]), 64'd5);
    step();
    check("t1_after", 64'(wb_valid_o), 64'd0);

    // High-half selects with each signedness.
    run_op("t2_mulh",   2'd1, 32'h8000_0000, 32'h8000_0000, res);
    check("t2_mulh_d",   64'(res), 64'h4000_0000);
    run_op("t2_mulhu",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res);
    check("t2_mulhu_d",  64'(res), 64'hFFFF_FFFE);
    run_op("t2_mulhsu", 2'd2, 32'hFFFF_FFFF, 32'd2, res);
    check("t2_mulhsu_d", 64'(res), 64'hFFFF_FFFF);
    run_op("t2_mul",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res);
    check("t2_mul_d",    64'(res), 64'd1);
    run_op("t2_mulh_n", 2'd1, 32'hFFFF_FFFD, 32'd5, res);
    check("t2_mulh_n_d", 64'(res), 64'hFFFF_FFFF);

    // Back-to-back five ops with three cycles of writeback back-pressure.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 32'(i + 1), 32'd10, 5'(i + 1));
      check($sformatf("t3_rdy_%0d", i), 64'(in_ready_o), 64'd1);
      step();
    end
    in_valid_i = 1'b0;
    check("t3_first_wbv", 64'(wb_valid_o), 64'd1);
    wb_ready_i = 1'b0;
    #1;
    snap_data = fwd_data_o;
    snap_en   = fwd_en_snapshot();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t3_hold_rdy_%0d", c), 64'(in_ready_o), 64'd0);
      check($sformatf("t3_hold_en_%0d", c),  64'(fwd_wr_en_o), 64'(snap_en));
      check($sformatf("t3_hold_d_%0d", c),   64'(fwd_data_o == snap_data), 64'd1);
      if (c < 2) step();
    end
    wb_ready_i = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (wb_valid_o && wb_ready_i) got_q.push_back(wb_data_o);
      step();
    end
    check("t3_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_res_%0d", i),
            (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'(10 * (i + 1)));
    end

    // Flush with three ops in flight and a same-cycle issue.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 32'd2, 32'(i), 5'(6 + i));
      step();
    end
    drive(1'b1, 2'd0, 32'd3, 32'd3, 5'd9);
    flush_i = 1'b1;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("t4_fwden", 64'(fwd_wr_en_o), 64'd0);
    check("t4_busy",  64'(busy_mask_o), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen |= wb_valid_o;
      step();
    end
    check("t4_no_wb", 64'(seen), 64'd0);

    // x0 destination never forwards, writes back or holds.
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd0, 32'd3, 32'd4, 5'd0);
    step();
    in_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen |= (fwd_wr_en_o != '0) || wb_valid_o || !in_ready_o;
      if (c == 4) check("t5_st5_data", 64'(lane(4)), 64'd12);
      step();
    end
    check("t5_quiet", 64'(seen), 64'd0);
    wb_ready_i = 1'b1;

    // Two ops to x9 one cycle apart.
    drive(1'b1, 2'd0, 32'd2, 32'd3, 5'd9);
    step();
    drive(1'b1, 2'd0, 32'd4, 32'd5, 5'd9);
    check("t6_en_s1", 64'(fwd_wr_en_o), 64'b00001);
`ifdef MULT_SCOREBOARD_EN
    check("t6_busy_s1", 64'(busy_mask_o), 64'(32'h1 << 9));
`endif
    step();
    in_valid_i = 1'b0;
    check("t6_en_s2", 64'(fwd_wr_en_o), 64'b00011);
    for (int s = 2; s <= 7; s++) begin
`ifdef MULT_SCOREBOARD_EN
      check($sformatf("t6_busy_%0d", s), 64'(busy_mask_o), (s < 7) ? 64'(32'h1 << 9) : 64'd0);
`endif
      if (s == 5) check("t6_wb_a", 64'(wb_data_o), 64'd6);
      if (s == 6) check("t6_wb_b", 64'(wb_data_o), 64'd20);
      if (s < 7) step();
    end
    check("t6_empty", 64'(fwd_wr_en_o), 64'd0);

    // Async reset mid-flight discards everything immediately.
    drive(1'b1, 2'd0, 32'd9, 32'd9, 5'd3);
    step();
    in_valid_i = 1'b0;
    step();
    check("t7_pre_en", 64'(fwd_wr_en_o), 64'b00010);
    rsn_i = 1'b0;
    #1;
    check("t7_rst_en",   64'(fwd_wr_en_o), 64'd0);
    check("t7_rst_wbv",  64'(wb_valid_o),  64'd0);
    check("t7_rst_ad",   64'(fwd_addr_o),  64'd0);
    check("t7_rst_d",    64'(|fwd_data_o), 64'd0);
    check("t7_rst_busy", 64'(busy_mask_o), 64'd0);
    #1;
    rsn_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      seen |= wb_valid_o;
    end
    check("t7_no_wb", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [NS-1:0] fwd_en_snapshot();
    return fwd_wr_en_o;
  endfunction

endmodule
